pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised, elastic pipeline stage register for the core pipeline, the successor of the fixed inter-stage registers. It carries a generic control field and a generic data payload between two stages using a valid/ready handshake, with stall, flush, and a kill on control bits when the stage holds a bubble. An optional skid entry gives full throughput with a registered `ready_in`, which cuts the combinational stall path between stages.

## Interface
- `CTRL_W`, default 8: width of the control field (regWrite, memWrite, resultSrc, funct3, …). Forced to zero whenever the stage holds no valid entry.
- `DATA_W`, default 133: width of the payload (ALU result, store data, immediate, write address, PC+4, …). Never forced to zero.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  discards every held entry and any input offered in the same cycle.
- `valid_in`  in  1  upstream entry is valid.
- `ready_in`  out  1  the stage accepts input this cycle.
- `ctrl_in`  in  CTRL_W  upstream control field.
- `data_in`  in  DATA_W  upstream payload.
- `valid_out`  out  1  the output entry is valid.
- `ready_out`  in  1  downstream consumes the output this cycle.
- `ctrl_out`  out  CTRL_W  output control field; equals `M.ctrl` when `valid_out`=1, otherwise 0.
- `data_out`  out  DATA_W  output payload; holds the last loaded value.

## Operation
Storage:
- Main register M: `M.v`, `M.ctrl`, `M.data`. Drives the outputs.
- Skid register S: `S.v`, `S.ctrl`, `S.data`. Exists only with `PIPE_SKID_EN`.

Handshake definitions:
- Accept: `valid_in & ready_in & !flush_i`.
- Consume: `valid_out & ready_out`.

Priority, evaluated each cycle from highest to lowest:
1. `rst`: M.v = S.v = 0; all ctrl and data registers = 0.
2. `flush_i`: M.v = S.v = 0; M.ctrl = S.ctrl = 0; data registers keep their values; input is dropped.
3. Otherwise, when M is empty or being consumed (`!M.v | ready_out`):
   - If S.v = 1: M loads S and S.v becomes 0.
   - If S.v = 0: M loads the input. M.v = accept. M.ctrl = 0 when there is no accept. M.data loads only on accept.
4. Otherwise (M is held): an accept loads S and sets S.v = 1. This case exists only with skid.

Properties:
- The stage is a two-state occupancy machine: EMPTY, FULL. With skid it adds a third state, SKID (M and S both full).
- Transitions: EMPTY→FULL on accept. FULL→EMPTY on consume without accept. FULL→SKID on accept while held. SKID→FULL on consume. Any state→EMPTY on flush.
- Order is preserved. No entry is duplicated or lost, except through flush or reset.
- A consume and an accept in the same cycle with M full and S empty: M takes the new entry and occupancy is unchanged.

## Timing
- Latency from `data_in` to `data_out` is 1 cycle when not stalled.
- Throughput is 1 entry per cycle while `ready_out` is held high.
- `valid_out`, `ctrl_out` and `data_out` are driven directly from registers, with no input-to-output combinational path.
- `ctrl_out` is gated by M.v only.
- After reset, all outputs are 0. `ready_in` is 1 in the cycle after reset is released; it is also 1 during reset with skid, and 1 without skid.
- Flush takes effect at the next edge: `valid_out` = 0 in the following cycle.
- Reset asserted in the middle of a transfer drops the entry; there is no partial state.
- While `valid_out` = 1 and `ready_out` = 0, `ctrl_out` and `data_out` must stay stable.

## Configuration
- `PIPE_SKID_EN` defined:
  - The skid entry S is present.
  - `ready_in` = `!S.v`, driven from a register.
  - The stage sustains 1 entry per cycle across a single-cycle stall without a bubble.
- `PIPE_SKID_EN` undefined:
  - No S register.
  - `ready_in` = `!M.v | ready_out`, which is combinational from `ready_out`.
  - Rule 4 never applies.
  - Storage capacity is 1 entry.

## Test plan
- Reset then stream: hold `rst`=1 for 2 cycles, then send data 0x1..0x5 back-to-back with `ctrl_in`=0xFF and `ready_out`=1. Expect all outputs 0 during reset, then `data_out` = 0x1..0x5 on consecutive cycles starting 1 cycle after the first accept, with `ctrl_out`=0xFF.
- Bubble kill: drive `valid_in`=0 with `ctrl_in`=0xFF. Expect `valid_out`=0, `ctrl_out`=0x00, and `data_out` holding its previous value.
- Stall (skid build): send entries A, B, C with `ready_out`=0 from the cycle after A is accepted. Expect A held stable, B in S, `ready_in`=0, and C not accepted. Release `ready_out` and expect A, B, C in order with no loss. Without skid: B is not accepted until A is consumed.
- Flush vs accept: in SKID state assert `flush_i` together with `valid_in`=1. Expect `valid_out`=0 and `ctrl_out`=0 next cycle, the input discarded, and the next entry emerging alone.
- Simultaneous consume and accept: with M full and S empty, set `ready_out`=1 and `valid_in`=1 (D). Expect `data_out`=D next cycle, S.v stays 0, `ready_in` stays 1.
- Reset mid-stall: with the stage in SKID, assert `rst`. Expect `valid_out`=0, `ctrl_out`=0, `data_out`=0 next cycle, and no stale entry after release.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic valid/ready pipeline register with stall, flush and bubble ctrl kill
// Ports: clk, rst (sync, active-high), flush_i, valid_in/ready_in/ctrl_in/data_in (upstream),
//        valid_out/ready_out/ctrl_out/data_out (downstream).
// Define PIPE_SKID_EN to add a skid entry that registers ready_in and keeps full throughput.
module pipe_stage_elastic #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 133
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out
);
  logic              m_v_q, m_v_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_v, acc, adv, ld_m;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;
  assign acc  = valid_in & ready_in & !flush_i;
  assign adv  = !m_v_q | ready_out;
  assign ld_m = !flush_i & adv;
`ifdef PIPE_SKID_EN
  logic              s_v_q, s_v_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  assign s_v      = s_v_q;
  assign s_ctrl   = s_ctrl_q;
  assign s_data   = s_data_q;
  assign ready_in = !s_v_q;
  // S only fills while M is held; when M advances it drains S first
  always_comb begin
    s_v_d    = flush_i ? 1'b0 : adv ? 1'b0 : (s_v_q | acc);
    s_ctrl_d = flush_i ? '0 : (!adv & acc) ? ctrl_in : s_ctrl_q;
    s_data_d = (!flush_i & !adv & acc) ? data_in : s_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_v_q    <= 1'b0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      s_v_q    <= s_v_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end
`else
  assign s_v      = 1'b0;
  assign s_ctrl   = '0;
  assign s_data   = '0;
  assign ready_in = adv;
`endif
  always_comb begin
    m_v_d    = flush_i ? 1'b0 : adv ? (s_v | acc) : m_v_q;
    m_ctrl_d = flush_i ? '0 : adv ? (s_v ? s_ctrl : acc ? ctrl_in : '0) : m_ctrl_q;
    m_data_d = !ld_m ? m_data_q : s_v ? s_data : acc ? data_in : m_data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      m_ctrl_q <= '0;
      m_data_q <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
    end
  end
  assign valid_out = m_v_q;
  assign ctrl_out  = m_v_q ? m_ctrl_q : '0;
  assign data_out  = m_data_q;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;
  localparam int CW = 8;
  localparam int DW = 133;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  logic          clk = 1'b0;
  logic          rst, flush_i, valid_in, ready_in, valid_out, ready_out;
  logic [CW-1:0] ctrl_in, ctrl_out;
  logic [DW-1:0] data_in, data_out;
  ent_t          src[$];
  ent_t          sb[$];
  logic [DW-1:0] last_d;
  int            checks = 0;
  int            failures = 0;
  pipe_stage_elastic #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .valid_in(valid_in), .ready_in(ready_in), .ctrl_in(ctrl_in), .data_in(data_in),
    .valid_out(valid_out), .ready_out(ready_out), .ctrl_out(ctrl_out), .data_out(data_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction
  task automatic push(input logic [CW-1:0] c, input logic [DW-1:0] d);
    ent_t e;
    e.c = c;
    e.d = d;
    src.push_back(e);
  endtask
  // Called at a negedge: drive, check against the model, then advance the model one edge.
  task automatic step(input bit ro, input bit fl);
    ent_t e;
    bit rdy, acc, con;
    e = src.size() > 0 ? src[0] : '0;
    valid_in  = src.size() > 0;
    ctrl_in   = src.size() > 0 ? e.c : 8'hFF;
    data_in   = src.size() > 0 ? e.d : '1;
    ready_out = ro;
    flush_i   = fl;
    rdy = SKID ? (sb.size() < 2) : (sb.size() == 0 || ro);
    #1;
    chk("valid_out", valid_out, sb.size() > 0);
    chk("ctrl_out", ctrl_out, sb.size() > 0 ? sb[0].c : 8'h00);
    chk("data_out", data_out, last_d);
    chk("ready_in", ready_in, rdy);
    acc = valid_in & rdy & !fl;
    con = (sb.size() > 0) & ro;
    if (fl) begin
      sb.delete();
      if (valid_in) void'(src.pop_front());
    end else begin
      if (con) void'(sb.pop_front());
      if (acc) sb.push_back(src.pop_front());
    end
    if (sb.size() > 0) last_d = sb[0].d;
    @(negedge clk);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    valid_in = 1'b0;
    flush_i = 1'b0;
    ready_out = 1'b0;
    ctrl_in = 8'hFF;
    data_in = '1;
    src.delete();
    sb.delete();
    last_d = '0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_ctrl_out", ctrl_out, 8'h00);
      chk("rst_data_out", data_out, '0);
    end
    rst = 1'b0;
  endtask
  initial begin
    do_reset(2);
    for (int i = 1; i <= 5; i++) push(8'hFF, DW'(i));
    repeat (6) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    push(8'hA1, rnd());
    push(8'hB2, rnd());
    push(8'hC3, rnd());
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    push(8'h11, rnd());
    push(8'h22, rnd());
    push(8'h33, rnd());
    push(8'h44, rnd());
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    push(8'h55, rnd());
    push(8'h66, rnd());
    push(8'h77, rnd());
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    do_reset(1);
    repeat (3) step(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1, 0) == 1) push(CW'($urandom), rnd());
      step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);
    end
    repeat (6) step(1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
